instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Supplies the instruction stream consumed by the control decoder; it is the producer end of the decode interface.
- Maintains the PC and issues single-outstanding word fetches to instruction memory.
- Buffers returned words in a small queue and presents them with a valid/ready handshake.
- Handles redirects (branch/call/ret targets) and stops fetching on the HALT word (16'hFFFF).

Parameters:
PC_W, 16, PC / instruction-memory word-address width
QDEPTH, 2, instruction queue depth (power of two, >=2)
RESET_PC, 16'h0000, PC value loaded at reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  PC_W  word address of fetch, stable while imem_req high
imem_ack  in  1  memory completes request; imem_rdata valid this cycle
imem_rdata  in  16  fetched instruction word
instr_valid  out  1  instr/instr_pc hold a valid queue head
instr  out  16  instruction to decoder
instr_pc  out  PC_W  address of instr
instr_ready  in  1  decoder accepts head this cycle
redirect  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  PC_W  new fetch address
halted  out  1  HALT word has been accepted by decoder; sticky until reset

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0.
  - Queue empty, PC=RESET_PC, state FETCH.
- States:
  - FETCH: normal operation.
  - DISCARD: waiting for a squashed response.
  - HALT_PEND: HALT word queued, no further fetches.
  - HALTED.
- Issue rule:
  - In FETCH, assert imem_req when no request is outstanding and (queue count + outstanding) < QDEPTH.
  - imem_addr=PC. Earliest request is the first cycle after reset release.
- Memory protocol:
  - Once asserted, imem_req and imem_addr must not change until imem_ack; imem_req drops the cycle after ack unless a new request issues.
  - Ack may arrive in the request cycle or later.
  - Ack in cycle N enqueues {imem_rdata, imem_addr}, and PC <= PC+1 (wraps 16'hFFFF -> 16'h0000).
  - A new request may issue in cycle N+1.
- Latency: ack in cycle N with empty queue gives instr_valid=1 in cycle N+1.
- Output handshake:
  - Head dequeues when instr_valid && instr_ready.
  - instr and instr_pc are stable while instr_valid && !instr_ready.
  - Queue full: no issue. Queue never overflows.
- HALT:
  - An enqueued word == 16'hFFFF moves the state to HALT_PEND; no further requests are issued.
  - When that word is dequeued, the state moves to HALTED and halted <= 1 the next cycle.
  - HALTED is exited only by reset.
- Redirect (FETCH or HALT_PEND):
  - Queue flushed and PC <= redirect_pc.
  - HALT_PEND cancels back to FETCH.
  - If a request is outstanding and not acked this cycle, go to DISCARD and keep imem_req/imem_addr unchanged until ack. The ack's data is dropped, then return to FETCH and request redirect_pc.
- Simultaneous events:
  - Redirect with ack in the same cycle: data dropped, no DISCARD, request at redirect_pc next cycle.
  - Redirect with a dequeue in the same cycle: the dequeue transfer completes; all remaining entries are flushed; instr_valid=0 next cycle.
  - Redirect in DISCARD: overwrites the target PC.
  - Redirect in HALTED: ignored.
- Mid-operation reset: all state returns to reset values immediately, regardless of outstanding request; memory is required to tolerate an abandoned request.

Decomposition:
- Shared package wisc_pkg holds:
  - opcode localparams (ADD..ERR)
  - HALT_WORD=16'hFFFF
  - the fetch state enum {FETCH, DISCARD, HALT_PEND, HALTED}
- Sub-module fetch_queue: parameterised FIFO of {instr, pc} with push, pop, synchronous flush, count, full, empty. It uses the same clk/rst_n.

Test Plan:
- Reset release, memory acks in request cycle, instr_ready=1 → imem_addr 0,1,2,…; instr_valid first high two cycles after reset release; instr_pc matches the memory contents' addresses.
- Memory with 3-cycle ack latency, instr_ready held 0 → exactly QDEPTH=2 words queued; imem_req low thereafter; instr/instr_pc stable; raising ready resumes fetching.
- Request to addr 5 outstanding, redirect to 16'h0040 before ack → imem_req/addr stay at 5 until ack; word from 5 never appears; next request at 16'h0040.
- Memory returns 16'hFFFF at addr 3 → no request for addr 4; halted=1 the cycle after the FFFF is accepted; a later redirect is ignored.
- Redirect to 16'hFFFE → fetch addresses FFFE, FFFF, 0000 (wrap).
- Assert rst_n=0 while imem_req high and queue full → next cycle all outputs at reset values; after release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC core: opcodes, HALT encoding,
// and the fetch-unit state type.
package wisc_pkg;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_CAL = 4'h8;
  localparam logic [3:0] OP_RET = 4'h9;
  localparam logic [3:0] OP_ERR = 4'hF;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    FETCH,
    DISCARD,
    HALT_PEND,
    HALTED
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_queue.sv
// Small FIFO of {instr, pc} pairs between memory and decoder.
// Flush wins over push; a pop in the flush cycle still completes.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [15:0]                  push_instr,
  input  logic [PC_W-1:0]              push_pc,
  input  logic                         pop,
  input  logic                         flush,
  output logic [15:0]                  head_instr,
  output logic [PC_W-1:0]              head_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  typedef logic [CNT_W-1:0] cnt_t;

  logic [15:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign full       = (count == cnt_t'(DEPTH));
  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        instr_mem[wr_ptr] <= push_instr;
        pc_mem[wr_ptr]    <= push_pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, queued
// valid/ready delivery to decode, redirects and HALT detection.
module instr_fetch_unit
  import wisc_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              QDEPTH   = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            instr_valid,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);
  localparam int CNT_W = $clog2(QDEPTH+1);
  typedef logic [CNT_W:0] cnt_t;

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [CNT_W-1:0] q_count;
  logic q_full;
  logic q_empty;
  logic acked;
  logic push;
  logic pop;
  logic flush;
  logic can_issue;
  cnt_t cnt_nxt;

  assign acked       = imem_req && imem_ack;
  assign instr_valid = !q_empty;
  assign pop         = instr_valid && instr_ready;
  assign flush       = redirect && (state != HALTED);
  assign push        = acked && (state == FETCH) && !redirect
                     && (!q_full || pop);
  assign pc_inc      = pc + PC_W'(1);

  // Occupancy after this edge decides whether the next fetch fits.
  always_comb begin
    cnt_nxt = cnt_t'(q_count) + cnt_t'(push) - cnt_t'(pop);
    if (flush)
      cnt_nxt = '0;
  end

  assign can_issue = (!imem_req || imem_ack)
                   && (cnt_nxt < cnt_t'(QDEPTH));

  fetch_queue #(
    .DEPTH (QDEPTH),
    .PC_W  (PC_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_instr (imem_rdata),
    .push_pc    (imem_addr),
    .pop        (pop),
    .flush      (flush),
    .head_instr (instr),
    .head_pc    (instr_pc),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      halted    <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (imem_req && !imem_ack) begin
              state <= DISCARD;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= redirect_pc;
            end
          end else begin
            if (push)
              pc <= pc_inc;
            if (push && imem_rdata == HALT_WORD) begin
              state    <= HALT_PEND;
              imem_req <= 1'b0;
            end else if (can_issue) begin
              imem_req  <= 1'b1;
              imem_addr <= push ? pc_inc : pc;
            end else if (acked) begin
              imem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          // Squashed request stays on the bus until memory answers.
          if (redirect)
            pc <= redirect_pc;
          if (imem_ack) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= redirect ? redirect_pc : pc;
          end
        end
        HALT_PEND: begin
          if (redirect) begin
            state     <= FETCH;
            pc        <= redirect_pc;
            imem_req  <= 1'b1;
            imem_addr <= redirect_pc;
          end else if (pop && instr == HALT_WORD) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
        end
        default: begin
        end
      endcase
    end
  end
endmodule
